fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core, sitting directly upstream of the control decoder. It owns the program counter and issues one word-aligned read at a time to instruction memory over a req/ready + rvalid handshake. It holds each returned instruction in a valid/ready output register, exposing opcode and funct to the decoder. It consumes the decoder's `jmp`/`Branch` outputs together with the ALU zero flag to select the next PC.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_target_calc.sv | 28 ++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding, instruction field positions and PC constants.
// No logic; imported by fetch_unit and fetch_target_calc.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DRAIN = 3'd4
  } t_fetch_state;

  // Instruction field positions (MIPS R/I/J formats)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_calc.sv
// Next-PC candidates and decoder fields for the held instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a candidate is used.
module fetch_target_calc
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_pc_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] jump_tgt_o,
  output logic [31:0] branch_tgt_o,
  output logic [5:0]  opcode_o,
  output logic [5:0]  funct_o
);

  // Sequential successor, wraps mod 2^32
  assign pc_plus4_o   = instr_pc_i + PC_STEP;

  // J-format: keep the top nibble of the successor, splice in the word index
  assign jump_tgt_o   = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};

  // I-format: sign-extended word offset relative to the successor
  assign branch_tgt_o = pc_plus4_o + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  assign opcode_o     = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign funct_o      = instr_i[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read at a time, holds the result for decode.
// Latency: 3 cycles minimum per instruction (FETCH -> WAIT -> VALID) with zero-wait memory.
// Backpressure: the held instruction stays put until instr_ready; no new request is issued meanwhile.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] instr_pc,
  input  logic        jmp,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] fetch_cnt
);

  t_fetch_state state_q;
  logic [31:0]  pc_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic [31:0]  fetch_cnt_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  jump_tgt;
  logic [31:0]  branch_tgt;
  logic [31:0]  next_pc_d;

  fetch_target_calc u_target (
    .instr_i      (instr_q),
    .instr_pc_i   (instr_pc_q),
    .pc_plus4_o   (pc_plus4),
    .jump_tgt_o   (jump_tgt),
    .branch_tgt_o (branch_tgt),
    .opcode_o     (opcode),
    .funct_o      (funct)
  );

  // Next PC on accept: jump beats taken branch beats fall-through
  always_comb begin
    next_pc_d = pc_plus4;
    if (jmp) begin
      next_pc_d = jump_tgt;
    end else if (branch && alu_zero) begin
      next_pc_d = branch_tgt;
    end
  end

  // Fetch FSM with PC, held-instruction register and accept counter.
  // A flush that coincides with the owed response in WAIT/DRAIN drops that response
  // and goes straight back to FETCH, since nothing is outstanding any more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      fetch_cnt_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (flush) begin
            pc_q <= flush_pc;
            if (imem_ready) begin
              state_q    <= S_DRAIN;
              imem_req_q <= 1'b0;
            end
          end else if (imem_ready) begin
            state_q    <= S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (flush) begin
            pc_q <= flush_pc;
            if (imem_rvalid) begin
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (imem_rvalid) begin
            state_q       <= S_VALID;
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (flush) begin
            pc_q          <= flush_pc;
            state_q       <= S_FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end else if (instr_ready) begin
            pc_q          <= next_pc_d;
            fetch_cnt_q   <= fetch_cnt_q + 32'd1;
            state_q       <= S_FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            pc_q <= flush_pc;
          end
          if (imem_rvalid) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic.
// A transaction-level model predicts request, held instruction and count every cycle.
// Memory and decode sides are driven with random stalls, spurious rvalid and flushes.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic        jmp;
  logic        branch;
  logic        alu_zero;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  // memory-side behaviour knobs
  int mem_delay = 1;   // >0: fixed response delay, 0: random 1..3
  bit rand_mode = 0;   // random ready stalls and spurious rvalid

  logic [31:0] mem [logic [31:0]];

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .instr_pc(instr_pc),
    .jmp(jmp), .branch(branch), .alu_zero(alu_zero),
    .flush(flush), .flush_pc(flush_pc), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Next PC straight from the ISA rules
  function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          off;
    p4  = ipc + 32'd4;
    off = $signed(ins[15:0]);
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b && z) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!imem_req && n < 30) begin tick(); n++; end
    chk({nm, "_req_seen"}, imem_req, 1'b1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 30) begin tick(); n++; end
    chk({nm, "_valid_seen"}, instr_valid, 1'b1);
  endtask

  // Memory responder: one outstanding read, response 1+ cycles after the handshake
  initial begin : mem_drv
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] maddr;
    bit          busy;
    int          cnt;
    busy = 0; cnt = 0; maddr = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        continue;
      end
      if (busy && imem_rvalid) busy = 0;
      if (req_s && imem_ready) begin
        busy  = 1;
        maddr = addr_s;
        cnt   = (mem_delay > 0) ? mem_delay : int'($urandom_range(1, 3));
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memfn(maddr);
        end
      end else if (rand_mode && $urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end
      imem_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Transaction-level model: what is requested, what is owed, what is held
  initial begin : model
    bit          started, m_req, m_out, m_keep, m_held, owed;
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    started = 0; m_req = 0; m_out = 0; m_keep = 0; m_held = 0; owed = 0;
    m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 0; m_req = 0; m_out = 0; m_keep = 0; m_held = 0;
        m_pc = RESET_PC; m_cnt = '0;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        continue;
      end
      chk("m_req", imem_req, m_req);
      chk("m_valid", instr_valid, m_held);
      chk("m_cnt", fetch_cnt, m_cnt);
      if (m_req) chk("m_addr", imem_addr, m_pc);
      if (m_held) begin
        chk("m_instr", instr, m_instr);
        chk("m_instr_pc", instr_pc, m_ipc);
        chk("m_opcode", opcode, m_instr >> 26);
        chk("m_funct", funct, m_instr & 32'h3F);
      end
      if (!started) begin
        started = 1;
        m_req   = 1;
        continue;
      end
      if (flush) begin
        owed   = (m_out && !imem_rvalid) || (m_req && imem_ready);
        m_pc   = flush_pc;
        m_held = 0;
        m_out  = owed;
        m_keep = 0;
        m_req  = !owed;
      end else if (m_req) begin
        if (imem_ready) begin m_req = 0; m_out = 1; m_keep = 1; end
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out = 0;
          if (m_keep) begin
            m_held  = 1;
            m_ipc   = m_pc;
            m_instr = memfn(m_pc);
          end else begin
            m_req = 1;
          end
        end
      end else if (m_held && instr_ready) begin
        m_cnt  = m_cnt + 32'd1;
        m_pc   = model_next(m_ipc, m_instr, jmp, branch, alu_zero);
        m_held = 0;
        m_req  = 1;
      end
    end
  end

  initial begin : main
    rst_n = 1'b0; instr_ready = 1'b1; jmp = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    flush = 1'b0; flush_pc = '0;
    mem[32'h0000_0000] = 32'h012A_4020;
    mem[32'h0000_0004] = 32'h8D09_0004;
    mem[32'h0000_0100] = 32'h0800_0010;
    mem[32'h0000_0020] = 32'h1000_FFFF;

    // pin the reference next-PC rules with hand-computed values
    chk("pin_jump", model_next(32'h100, 32'h0800_0010, 1'b1, 1'b0, 1'b0), 32'h40);
    chk("pin_beq_taken", model_next(32'h20, 32'h1000_FFFF, 1'b0, 1'b1, 1'b1), 32'h20);
    chk("pin_beq_not", model_next(32'h20, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0), 32'h24);
    chk("pin_wrap", model_next(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0), 32'h0);

    repeat (3) tick();
    rst_n = 1'b1;

    // straight-line fetch
    wait_req("sl0");
    chk("sl_addr0", imem_addr, 32'h0);
    wait_valid("sl0");
    chk("sl_opcode0", opcode, 32'h00);
    chk("sl_funct0", funct, 32'h20);
    tick();
    wait_req("sl1");
    chk("sl_addr1", imem_addr, 32'h4);
    wait_valid("sl1");
    chk("sl_opcode1", opcode, 32'h23);
    tick();
    wait_req("sl2");
    chk("sl_addr2", imem_addr, 32'h8);
    chk("sl_cnt", fetch_cnt, 32'd2);

    // jump: redirect to 0x100, then take the jump
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0; jmp = 1'b1;
    wait_valid("jmp");
    chk("jmp_instr_pc", instr_pc, 32'h100);
    tick();
    jmp = 1'b0;
    wait_req("jmp");
    chk("jmp_addr", imem_addr, 32'h40);
    chk("jmp_cnt", fetch_cnt, 32'd3);

    // branch taken then not taken
    flush = 1'b1; flush_pc = 32'h20;
    tick();
    flush = 1'b0; branch = 1'b1; alu_zero = 1'b1;
    wait_valid("beq_t");
    chk("beq_instr", instr, 32'h1000_FFFF);
    tick();
    wait_req("beq_t");
    chk("beq_taken_addr", imem_addr, 32'h20);
    alu_zero = 1'b0;
    wait_valid("beq_n");
    tick();
    branch = 1'b0;
    wait_req("beq_n");
    chk("beq_not_addr", imem_addr, 32'h24);

    // backpressure on the held instruction
    instr_ready = 1'b0;
    mem_delay   = 3;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_instr", instr, memfn(32'h24));
      chk("bp_instr_pc", instr_pc, 32'h24);
      chk("bp_req", imem_req, 1'b0);
      chk("bp_cnt", fetch_cnt, 32'd5);
      tick();
    end
    instr_ready = 1'b1;
    tick();

    // flush while waiting for read data
    wait_req("fw");
    tick();
    flush = 1'b1; flush_pc = 32'h80;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fw_no_valid", instr_valid, 1'b0);
      chk("fw_no_req", imem_req, 1'b0);
      tick();
    end
    wait_req("fw");
    chk("fw_addr", imem_addr, 32'h80);
    chk("fw_cnt", fetch_cnt, 32'd6);
    mem_delay = 1;

    // async reset while holding an instruction
    instr_ready = 1'b0;
    wait_valid("ar");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_req", imem_req, 1'b0);
    chk("ar_cnt", fetch_cnt, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("ar_req_after", imem_req, 1'b1);
    chk("ar_addr_after", imem_addr, RESET_PC);

    // randomized traffic
    rand_mode = 1;
    mem_delay = 0;
    repeat (4000) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jmp         = ($urandom_range(0, 3) == 0);
      branch      = $urandom_range(0, 1);
      alu_zero    = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 11) == 0);
      flush_pc    = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    flush = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
